// File: rtl/msg_dispatch_controller.sv
// msg_dispatch_controller
// Routes bytes from the serial message receiver into the particle RAM or the
// map RAM, pulses a ready flag once a whole message has landed, and rejects
// particle messages that arrive while the filter core owns the particle RAM.
// Optional feature: define DISPATCH_DROP_COUNT_EN to build the saturating
// drop counter; otherwise drop_count is a constant 0.
module msg_dispatch_controller #(
    parameter int PARTICLE_BYTES = 16,
    parameter int MAP_BYTES      = 64,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        msg_byte,
    input  logic              msg_valid,
    input  logic              particle_data_flag,
    input  logic              map_data_flag,
    input  logic              core_busy,
    output logic              pwr_en,
    output logic [ADDR_W-1:0] pwr_addr,
    output logic [7:0]        pwr_data,
    output logic              mwr_en,
    output logic [ADDR_W-1:0] mwr_addr,
    output logic [7:0]        mwr_data,
    output logic              particle_ready,
    output logic              map_ready,
    output logic              loading,
    output logic [7:0]        drop_count
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] P_LAST = CW'(PARTICLE_BYTES - 1);
    localparam logic [CW-1:0] M_LAST = CW'(MAP_BYTES - 1);

    typedef enum logic [2:0] {IDLE, P_LOAD, M_LOAD, P_DROP, COMMIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          commit_particle, commit_particle_next;
    logic          p_wr, m_wr, drop_inc;

    // State register; reset abandons any partial message
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic plus the byte-count and write/drop decisions for this cycle
    always_comb begin
        state_next           = state;
        count_next           = count;
        commit_particle_next = commit_particle;
        p_wr                 = 1'b0;
        m_wr                 = 1'b0;
        drop_inc             = 1'b0;
        case (state)
            IDLE: begin
                if (msg_valid && particle_data_flag) begin
                    commit_particle_next = 1'b1;
                    count_next           = CW'(1);
                    if (core_busy) begin
                        if (P_LAST == '0) begin
                            drop_inc   = 1'b1;
                            count_next = '0;
                        end else begin
                            state_next = P_DROP;
                        end
                    end else begin
                        p_wr       = 1'b1;
                        state_next = (P_LAST == '0) ? COMMIT : P_LOAD;
                    end
                end else if (msg_valid && map_data_flag) begin
                    commit_particle_next = 1'b0;
                    count_next           = CW'(1);
                    m_wr                 = 1'b1;
                    state_next           = (M_LAST == '0) ? COMMIT : M_LOAD;
                end
            end
            P_LOAD: begin
                if (core_busy || (msg_valid && !particle_data_flag)) begin
                    drop_inc   = 1'b1;
                    count_next = '0;
                    state_next = IDLE;
                end else if (msg_valid) begin
                    p_wr       = 1'b1;
                    count_next = count + CW'(1);
                    if (count == P_LAST) state_next = COMMIT;
                end
            end
            M_LOAD: begin
                if (msg_valid && !map_data_flag) begin
                    drop_inc   = 1'b1;
                    count_next = '0;
                    state_next = IDLE;
                end else if (msg_valid) begin
                    m_wr       = 1'b1;
                    count_next = count + CW'(1);
                    if (count == M_LAST) state_next = COMMIT;
                end
            end
            P_DROP: begin
                if (msg_valid) begin
                    if (count == P_LAST) begin
                        drop_inc   = 1'b1;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
            end
            COMMIT: begin
                count_next = '0;
                state_next = IDLE;
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: ready pulses come from COMMIT, which coincides with the last write strobe
    always_comb begin
        loading        = (state != IDLE);
        particle_ready = (state == COMMIT) && commit_particle;
        map_ready      = (state == COMMIT) && !commit_particle;
    end

    // Registered write ports and byte count; address and data hold between strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            count           <= '0;
            commit_particle <= 1'b0;
            pwr_en          <= 1'b0;
            pwr_addr        <= '0;
            pwr_data        <= '0;
            mwr_en          <= 1'b0;
            mwr_addr        <= '0;
            mwr_data        <= '0;
        end else begin
            count           <= count_next;
            commit_particle <= commit_particle_next;
            pwr_en          <= p_wr;
            mwr_en          <= m_wr;
            if (p_wr) begin
                pwr_addr <= count[ADDR_W-1:0];
                pwr_data <= msg_byte;
            end
            if (m_wr) begin
                mwr_addr <= count[ADDR_W-1:0];
                mwr_data <= msg_byte;
            end
        end
    end

`ifdef DISPATCH_DROP_COUNT_EN
    logic [7:0] drop_q;

    // Saturating count of rejected and aborted messages
    always_ff @(posedge clk) begin
        if (!reset)                          drop_q <= '0;
        else if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

    assign drop_count = drop_q;
`else
    logic drop_unused;
    assign drop_unused = drop_inc;
    assign drop_count  = 8'd0;
`endif

endmodule

// File: tb/tb_msg_dispatch_controller.sv
// tb_msg_dispatch_controller
// Directed bench for msg_dispatch_controller. A message-level model predicts
// every output each cycle; scenario results are also pinned to literal values.
// Honours DISPATCH_DROP_COUNT_EN the same way as the design.
module tb_msg_dispatch_controller;

    localparam int PB = 16;
    localparam int MB = 64;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    msg_byte = 8'd0;
    logic          msg_valid = 1'b0;
    logic          pflag = 1'b0;
    logic          mflag = 1'b0;
    logic          core_busy = 1'b0;
    logic          pwr_en, mwr_en, particle_ready, map_ready, loading;
    logic [AW-1:0] pwr_addr, mwr_addr;
    logic [7:0]    pwr_data, mwr_data, drop_count;

    int checks = 0;
    int passes = 0;

    msg_dispatch_controller #(
        .PARTICLE_BYTES(PB), .MAP_BYTES(MB), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .msg_byte(msg_byte), .msg_valid(msg_valid),
        .particle_data_flag(pflag), .map_data_flag(mflag), .core_busy(core_busy),
        .pwr_en(pwr_en), .pwr_addr(pwr_addr), .pwr_data(pwr_data),
        .mwr_en(mwr_en), .mwr_addr(mwr_addr), .mwr_data(mwr_data),
        .particle_ready(particle_ready), .map_ready(map_ready),
        .loading(loading), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int expDrop(input int n);
`ifdef DISPATCH_DROP_COUNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    // Message-level model: kind 0 none, 1 particle, 2 map, 3 rejected particle
    int  kind = 0, pos = 0, drops = 0;
    bit  commit_cycle = 0;
    bit  e_pwr_en = 0, e_mwr_en = 0, e_pready = 0, e_mready = 0;
    int  e_paddr = 0, e_pdata = 0, e_maddr = 0, e_mdata = 0;
    bit  model_on = 0;

    always @(posedge clk) begin
        e_pwr_en = 0; e_mwr_en = 0; e_pready = 0; e_mready = 0;
        if (!reset) begin
            kind = 0; pos = 0; drops = 0; commit_cycle = 0;
            e_paddr = 0; e_pdata = 0; e_maddr = 0; e_mdata = 0;
        end else if (commit_cycle) begin
            commit_cycle = 0; kind = 0; pos = 0;
        end else begin
            if (kind == 0 && msg_valid && pflag && core_busy) begin
                kind = 3; pos = 1;
            end else if (kind == 0 && msg_valid && pflag) begin
                kind = 1;
            end else if (kind == 0 && msg_valid && mflag) begin
                kind = 2;
            end else if (kind == 1 && (core_busy || (msg_valid && !pflag))) begin
                kind = 0; pos = 0; drops++;
            end else if (kind == 2 && msg_valid && !mflag) begin
                kind = 0; pos = 0; drops++;
            end else if (kind == 3 && msg_valid) begin
                pos++;
                if (pos == PB) begin kind = 0; pos = 0; drops++; end
            end
            if (msg_valid && kind == 1 && !(core_busy)) begin
                e_pwr_en = 1; e_paddr = pos; e_pdata = msg_byte; pos++;
                if (pos == PB) begin e_pready = 1; commit_cycle = 1; end
            end else if (msg_valid && kind == 2) begin
                e_mwr_en = 1; e_maddr = pos; e_mdata = msg_byte; pos++;
                if (pos == MB) begin e_mready = 1; commit_cycle = 1; end
            end
        end
    end

    // Per-cycle comparison against the model plus scenario observation counters
    int pwr_cnt = 0, mwr_cnt = 0, pready_cnt = 0, mready_cnt = 0;
    int ready_paddr = -1, ready_maddr = -1, first_paddr = -1;
    int pram [256];

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("pwr_en", pwr_en, e_pwr_en);
            checkOutput("mwr_en", mwr_en, e_mwr_en);
            if (e_pwr_en) begin
                checkOutput("pwr_addr", pwr_addr, e_paddr);
                checkOutput("pwr_data", pwr_data, e_pdata);
            end
            if (e_mwr_en) begin
                checkOutput("mwr_addr", mwr_addr, e_maddr);
                checkOutput("mwr_data", mwr_data, e_mdata);
            end
            checkOutput("particle_ready", particle_ready, e_pready);
            checkOutput("map_ready", map_ready, e_mready);
            checkOutput("loading", loading, (kind != 0 || commit_cycle) ? 1 : 0);
            checkOutput("drop_count", drop_count, expDrop(drops));
        end
        if (pwr_en === 1'b1) begin
            if (pwr_cnt == 0) first_paddr = pwr_addr;
            pwr_cnt++;
            pram[pwr_addr] = pwr_data;
        end
        if (mwr_en === 1'b1) mwr_cnt++;
        if (particle_ready === 1'b1) begin pready_cnt++; ready_paddr = pwr_addr; end
        if (map_ready === 1'b1) begin mready_cnt++; ready_maddr = mwr_addr; end
    end

    task automatic clearCounters();
        pwr_cnt = 0; mwr_cnt = 0; pready_cnt = 0; mready_cnt = 0;
        ready_paddr = -1; ready_maddr = -1; first_paddr = -1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic pf, input logic mf, input logic busy);
        @(negedge clk);
        msg_byte = b; pflag = pf; mflag = mf; core_busy = busy; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendParticleMessage(input int base);
        for (int i = 0; i < PB; i++) applyStimulus(8'(base + i), 1'b1, 1'b0, 1'b0);
        idleCycles(3);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        idleCycles(2);
        model_on = 1;
        checkOutput("reset pwr_en", pwr_en, 0);
        checkOutput("reset mwr_en", mwr_en, 0);
        checkOutput("reset loading", loading, 0);
        checkOutput("reset drop_count", drop_count, 0);
        checkOutput("reset pwr_addr", pwr_addr, 0);
        checkOutput("reset mwr_data", mwr_data, 0);
        reset = 1'b1;
        idleCycles(2);

        // Stray byte with neither flag is ignored
        applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("stray loading", loading, 0);
        checkOutput("stray drop_count", drop_count, 0);

        // Particle load: bytes 1..16 to addr 0..15
        clearCounters();
        sendParticleMessage(1);
        checkOutput("p_load writes", pwr_cnt, 16);
        checkOutput("p_load ready pulses", pready_cnt, 1);
        checkOutput("p_load ready addr", ready_paddr, 15);
        checkOutput("p_load data0", pram[0], 1);
        checkOutput("p_load data15", pram[15], 16);
        checkOutput("p_load map writes", mwr_cnt, 0);
        checkOutput("p_load model drops", drops, 0);

        // Busy rejection
        clearCounters();
        for (int i = 0; i < PB; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b1);
        core_busy = 1'b0;
        idleCycles(2);
        checkOutput("reject writes", pwr_cnt, 0);
        checkOutput("reject ready", pready_cnt, 0);
        checkOutput("reject drop_count", drop_count, expDrop(1));
        checkOutput("reject loading", loading, 0);
        checkOutput("reject model drops", drops, 1);

        // Abort by core_busy after 5 bytes, then a clean message from addr 0
        clearCounters();
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        core_busy = 1'b1;
        idleCycles(2);
        core_busy = 1'b0;
        idleCycles(2);
        checkOutput("abort writes", pwr_cnt, 5);
        checkOutput("abort ready", pready_cnt, 0);
        checkOutput("abort drop_count", drop_count, expDrop(2));
        checkOutput("abort loading", loading, 0);
        clearCounters();
        sendParticleMessage(8'h40);
        checkOutput("after abort first addr", first_paddr, 0);
        checkOutput("after abort ready", pready_cnt, 1);
        checkOutput("after abort data0", pram[0], 8'h40);

        // Map load with core_busy toggling
        clearCounters();
        for (int i = 0; i < MB; i++) applyStimulus(8'(8'h80 + i), 1'b0, 1'b1, 1'(i % 2));
        core_busy = 1'b0;
        idleCycles(3);
        checkOutput("map writes", mwr_cnt, 64);
        checkOutput("map ready pulses", mready_cnt, 1);
        checkOutput("map ready addr", ready_maddr, 63);
        checkOutput("map particle writes", pwr_cnt, 0);

        // Map abort when the map flag drops mid-message
        clearCounters();
        for (int i = 0; i < 3; i++) applyStimulus(8'(i), 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("map abort writes", mwr_cnt, 3);
        checkOutput("map abort ready", mready_cnt, 0);
        checkOutput("map abort drop_count", drop_count, expDrop(3));

        // Priority on the first byte, then reset after byte 8
        clearCounters();
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) applyStimulus(8'(i + 1), 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("prio particle writes", pwr_cnt, 8);
        checkOutput("prio map writes", mwr_cnt, 0);
        checkOutput("mid reset pwr_en", pwr_en, 0);
        checkOutput("mid reset loading", loading, 0);
        checkOutput("mid reset pwr_addr", pwr_addr, 0);
        checkOutput("mid reset pwr_data", pwr_data, 0);
        checkOutput("mid reset drop_count", drop_count, 0);
        checkOutput("mid reset particle_ready", particle_ready, 0);
        reset = 1'b1;
        idleCycles(2);
        checkOutput("mid reset ready pulses", pready_cnt, 0);
        clearCounters();
        sendParticleMessage(8'h90);
        checkOutput("post reset first addr", first_paddr, 0);
        checkOutput("post reset ready", pready_cnt, 1);

        // Saturation: 300 rejected messages
        for (int m = 0; m < 300; m++)
            for (int i = 0; i < PB; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b1);
        core_busy = 1'b0;
        idleCycles(2);
`ifdef DISPATCH_DROP_COUNT_EN
        checkOutput("saturated drop_count", drop_count, 255);
`else
        checkOutput("disabled drop_count", drop_count, 0);
`endif
        checkOutput("saturation model drops", drops, 300);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/msg_dispatch_controller.md
MSG_DISPATCH_CONTROLLER -- requirements
Module: msg_dispatch_controller

Interface
REQ-001 Parameter PARTICLE_BYTES, default 16: bytes per particle message.
REQ-002 Parameter MAP_BYTES, default 64: bytes per map message.
REQ-003 Parameter ADDR_W, default 8: RAM write-address width; PARTICLE_BYTES and MAP_BYTES SHALL each be at most 2^ADDR_W.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 msg_byte  in  8  payload byte from the serial message receiver.
REQ-007 msg_valid  in  1  one-cycle strobe per byte; each high cycle is one new byte.
REQ-008 particle_data_flag  in  1  current message is particle data.
REQ-009 map_data_flag  in  1  current message is map data.
REQ-010 core_busy  in  1  filter core is reading particle RAM; particle loads are forbidden while high.
REQ-011 pwr_en / pwr_addr / pwr_data  out  1 / ADDR_W / 8  particle RAM write port.
REQ-012 mwr_en / mwr_addr / mwr_data  out  1 / ADDR_W / 8  map RAM write port.
REQ-013 particle_ready  out  1  one-cycle pulse: a complete particle set is in RAM.
REQ-014 map_ready  out  1  one-cycle pulse: a complete map message is in RAM.
REQ-015 loading  out  1  high in any state other than IDLE.
REQ-016 drop_count  out  8  count of rejected or aborted messages (see Configuration).

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, P_LOAD, M_LOAD, P_DROP, COMMIT.
REQ-018 IDLE, msg_valid with particle_data_flag and !core_busy: write the byte to particle address 0, set the byte count to 1, and go to P_LOAD.
REQ-019 IDLE, msg_valid with particle_data_flag and core_busy: discard the byte, set the count to 1, and go to P_DROP.
REQ-020 IDLE, msg_valid with map_data_flag only: write the byte to map address 0 and go to M_LOAD; map loads ignore core_busy.
REQ-021 IDLE, both flags set with msg_valid: particle takes priority and the map flag is ignored.
REQ-022 IDLE, msg_valid with neither flag: discard the byte and stay in IDLE; drop_count does not change.
REQ-023 Write strobes SHALL be registered: pwr_en/mwr_en, address and data are asserted in the cycle after msg_valid is sampled, and each strobe is exactly one cycle wide.
REQ-024 In P_LOAD and M_LOAD, each msg_valid writes to address = byte count, then the count increments; cycles without msg_valid hold all state.
REQ-025 Last byte (count = N-1) written in P_LOAD or M_LOAD: go to COMMIT.
REQ-026 COMMIT: pulse particle_ready or map_ready (according to the source state) for one cycle, in the same cycle as the last write strobe; then return to IDLE.
REQ-027 Abort in P_LOAD: if the message flag is low when msg_valid is sampled, or core_busy rises, return to IDLE, issue no ready pulse and no write, and increment drop_count.
REQ-028 Abort in M_LOAD: if the message flag is low when msg_valid is sampled, return to IDLE, issue no ready pulse and no write, and increment drop_count.
REQ-029 P_DROP: count msg_valid strobes without writing; on reaching PARTICLE_BYTES, return to IDLE and increment drop_count once.
REQ-030 The byte count SHALL be ADDR_W+1 bits wide and never wrap inside a message.
REQ-031 drop_count SHALL saturate at 255.

Reset
REQ-032 While reset = 0 at a clock edge, the block SHALL: enter IDLE; clear the count; drive pwr_en, mwr_en, particle_ready, map_ready, loading and drop_count to 0; clear both addresses and both data outputs to 0.
REQ-033 Reset mid-message SHALL discard the partial message with no ready pulse; the next message starts at address 0.

Configuration
REQ-034 Macro DISPATCH_DROP_COUNT_EN defined: drop_count behaves per REQ-027, REQ-028, REQ-029 and REQ-031.
REQ-035 Macro DISPATCH_DROP_COUNT_EN undefined: drop_count is tied to constant 0, no counter register is inferred, and all other behaviour is unchanged.

Verification
REQ-036 Particle load: 16 strobes, flag=1, core_busy=0, bytes 1..16 -> pwr writes at addr 0..15 with data 1..16; one particle_ready pulse in the cycle of the addr-15 write.
REQ-037 Busy rejection: core_busy=1, 16 particle bytes -> no pwr_en; no particle_ready; drop_count 0 -> 1; returns to IDLE.
REQ-038 Abort: core_busy rises after 5 particle bytes -> exactly 5 writes, no ready pulse, drop_count +1; next message writes from addr 0.
REQ-039 Map load: 64 strobes with map_data_flag, core_busy toggling throughout -> mwr writes at addr 0..63; one map_ready pulse; pwr_en never asserted.
REQ-040 Priority and reset: both flags on the first byte -> routed to particle RAM; reset=0 after byte 8 -> all outputs 0, IDLE, no ready pulse.
REQ-041 Saturation (macro defined): 300 rejected messages -> drop_count = 255; with the macro undefined, drop_count = 0.
